keccak_state_unpacker: RTL and testbench

- Downstream consumer of the Keccak hash stage; captures the 1600-bit final state when the hash signals done.
- Converts the state from MSByte-first to little-endian byte order.
- Presents static AES key material (k0, k1, a, b) to the explode/implode stages.
- Streams the eight 128-bit scratchpad-init blocks (state bytes 64..191) over a valid/ready handshake.

---
 rtl/keccak_state_unpacker_pkg.sv | 19 +
 rtl/keccak_state_unpacker_if.sv | 25 ++
 rtl/keccak_state_unpacker_byte_swap.sv | 15 +
 rtl/keccak_state_unpacker.sv | 130 +++++++++++++
 tb/tb_keccak_state_unpacker.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/keccak_state_unpacker_pkg.sv
// Shared constants, FSM state type and MSByte-first byte addressing helper.
package keccak_state_unpacker_pkg;

  localparam int KECCAK_STATE_BITS = 1600;
  localparam int AES_BLK_BITS      = 128;
  localparam int CN_INIT_BLKS      = 8;
  localparam int CN_BLK_OFS        = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Lowest bit of byte idx in an nbits-wide vector whose byte 0 sits at the top.
  function automatic int msb_byte_lo(input int nbits, input int idx);
    return nbits - 8 - 8 * idx;
  endfunction

endpackage

// File: rtl/keccak_state_unpacker_if.sv
// Capture and block-stream bus between the Keccak hash, the unpacker and the block consumer.
interface keccak_state_unpacker_if #(
  parameter int B = 1600,
  parameter int W = 128
);
  logic         done;
  logic [B-1:0] state;
  logic         ready;
  logic [W-1:0] blk;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;

  // Unpacker side: accepts captures, produces blocks.
  modport slave (
    input  done, state, blk_ready,
    output ready, blk, blk_valid, blk_last
  );

  // Environment side: hash output plus downstream block consumer.
  modport master (
    output done, state, blk_ready,
    input  ready, blk, blk_valid, blk_last
  );
endinterface

// File: rtl/keccak_state_unpacker_byte_swap.sv
// Combinational reorder of N bytes from MSByte-first to little-endian placement.
module keccak_byte_swap
  import keccak_state_unpacker_pkg::*;
#(
  parameter int N = 192
) (
  input  logic [8*N-1:0] msb_i,
  output logic [8*N-1:0] le_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_byte
    assign le_o[8*gi +: 8] = msb_i[msb_byte_lo(8*N, gi) +: 8];
  end

endmodule

// File: rtl/keccak_state_unpacker.sv
// Captures the final Keccak state, exposes key material and streams the scratchpad-init blocks.
module keccak_state_unpacker
  import keccak_state_unpacker_pkg::*;
#(
  parameter int B       = KECCAK_STATE_BITS,
  parameter int W       = AES_BLK_BITS,
  parameter int NBLK    = CN_INIT_BLKS,
  parameter int BLK_OFS = CN_BLK_OFS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  keccak_state_unpacker_if.slave bus,
  output logic                   o_keys_valid,
  output logic [255:0]           o_key0,
  output logic [255:0]           o_key1,
  output logic [127:0]           o_a,
  output logic [127:0]           o_b,
  output logic                   o_overflow
);

  // Only the leading bytes that feed keys and blocks are ever looked at.
  localparam int CAP_BYTES = BLK_OFS + NBLK * (W / 8);
  localparam int CAP_BITS  = 8 * CAP_BYTES;
  localparam int CW        = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBLK - 1);

  logic [CAP_BITS-1:0] cap_le;
  logic [127:0]        a_in;
  logic [127:0]        b_in;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;
  logic          ready_c;
  logic [W-1:0]  blk_q [NBLK];

  keccak_byte_swap #(.N(CAP_BYTES)) u_swap (
    .msb_i (bus.state[B-1 -: CAP_BITS]),
    .le_o  (cap_le)
  );

  if (B > CAP_BITS) begin : g_tail
    logic unused_tail;
    assign unused_tail = ^bus.state[B-CAP_BITS-1:0];
  end

  assign a_in = cap_le[127:0]   ^ cap_le[383:256];
  assign b_in = cap_le[255:128] ^ cap_le[511:384];

  // Next state, counter and capture decision; ready also reflects the final accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.done) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bus.blk_ready) begin
          if (cnt_q == CNT_LAST) begin
            ready_c = 1'b1;
            cnt_d   = '0;
            if (bus.done) capture = 1'b1;
            else          state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and block counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Key material, held from one capture to the next.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_key0       <= '0;
      o_key1       <= '0;
      o_a          <= '0;
      o_b          <= '0;
      o_keys_valid <= 1'b0;
    end else begin
      o_keys_valid <= capture;
      if (capture) begin
        o_key0 <= cap_le[255:0];
        o_key1 <= cap_le[511:256];
        o_a    <= a_in;
        o_b    <= b_in;
      end
    end
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    // Block store entry gi, loaded on capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     blk_q[gi] <= '0;
      else if (capture) blk_q[gi] <= cap_le[BLK_OFS*8 + gi*W +: W];
    end
  end

  // Sticky flag for a capture dropped while busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 o_overflow <= 1'b0;
    else if (bus.done && !ready_c) o_overflow <= 1'b1;
  end

  assign bus.ready     = ready_c & i_rst_n;
  assign bus.blk_valid = (state_q == ST_STREAM);
  assign bus.blk_last  = (state_q == ST_STREAM) && (cnt_q == CNT_LAST);
  assign bus.blk       = (state_q == ST_STREAM) ? blk_q[cnt_q] : '0;

endmodule

// File: tb/tb_keccak_state_unpacker.sv
// Directed bench for the Keccak state unpacker: capture, backpressure, back-to-back, overflow, reset.
module tb_keccak_state_unpacker;

  logic         clk;
  logic         rst_n;
  logic         keys_valid;
  logic [255:0] key0, key1;
  logic [127:0] a, b;
  logic         overflow;
  int           vectors;
  int           miscompares;
  logic [1599:0] st_inc, st_ff;

  keccak_state_unpacker_if #(.B(1600), .W(128)) bus ();

  keccak_state_unpacker dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus.slave),
    .o_keys_valid (keys_valid),
    .o_key0       (key0),
    .o_key1       (key1),
    .o_a          (a),
    .o_b          (b),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n bytes of st starting at byte first, little-endian packed.
  function automatic logic [255:0] le_range(input logic [1599:0] st, input int first, input int n);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = st[1599 - 8*(first + j) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] exp_blk(input logic [1599:0] st, input int k);
    logic [255:0] r;
    r = le_range(st, 64 + 16*k, 16);
    return r[127:0];
  endfunction

  // Pulse done with state st at the current negedge; return at the next negedge (t+1).
  task automatic do_capture(input logic [1599:0] st);
    bus.state = st;
    bus.done  = 1'b1;
    @(negedge clk);
    bus.done  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_keys_valid got=%0h exp=0", keys_valid); end
    vectors++; if (key0 !== '0 || key1 !== '0) begin miscompares++; $display("FAIL reset_keys got=%0h/%0h exp=0", key0, key1); end
    vectors++; if (a !== '0 || b !== '0) begin miscompares++; $display("FAIL reset_ab got=%0h/%0h exp=0", a, b); end
    vectors++; if (bus.blk_valid !== 1'b0 || bus.blk !== '0 || bus.blk_last !== 1'b0) begin miscompares++; $display("FAIL reset_blk got v=%0h d=%0h l=%0h exp=0", bus.blk_valid, bus.blk, bus.blk_last); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in got=%0h exp=0", bus.ready); end
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_out got=%0h exp=1", bus.ready); end
    $display("reset released");
    @(negedge clk);
  endtask

  task automatic test_basic;
    bus.blk_ready = 1'b1;
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle_ready got=%0h exp=1", bus.ready); end
    do_capture(st_inc);
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL basic_keys_valid got=%0h exp=1", keys_valid); end
    vectors++; if (key0[7:0] !== 8'h00 || key0[255:248] !== 8'h1F) begin miscompares++; $display("FAIL basic_key0_ends got=%0h/%0h exp=00/1f", key0[7:0], key0[255:248]); end
    vectors++; if (key1[7:0] !== 8'h20) begin miscompares++; $display("FAIL basic_key1_lo got=%0h exp=20", key1[7:0]); end
    vectors++; if (a[7:0] !== 8'h20 || b[7:0] !== 8'h20) begin miscompares++; $display("FAIL basic_ab_lo got=%0h/%0h exp=20/20", a[7:0], b[7:0]); end
    vectors++; if (key0 !== le_range(st_inc, 0, 32) || key1 !== le_range(st_inc, 32, 32)) begin miscompares++; $display("FAIL basic_keys_full got=%0h/%0h", key0, key1); end
    vectors++; if (a !== (le_range(st_inc, 0, 16) ^ le_range(st_inc, 32, 16)) || b !== (le_range(st_inc, 16, 16) ^ le_range(st_inc, 48, 16))) begin miscompares++; $display("FAIL basic_ab_full got=%0h/%0h", a, b); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (bus.blk_valid !== 1'b1 || bus.blk !== exp_blk(st_inc, k)) begin miscompares++; $display("FAIL basic_blk%0d got v=%0h d=%0h exp=%0h", k, bus.blk_valid, bus.blk, exp_blk(st_inc, k)); end
      vectors++; if (bus.blk_last !== (k == 7) || bus.ready !== (k == 7)) begin miscompares++; $display("FAIL basic_last_ready%0d got=%0h/%0h exp=%0h", k, bus.blk_last, bus.ready, (k == 7)); end
      if (k == 0) begin
        vectors++; if (bus.blk[7:0] !== 8'h40) begin miscompares++; $display("FAIL basic_blk0_lo got=%0h exp=40", bus.blk[7:0]); end
      end
      if (k == 1) begin
        vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL basic_keys_pulse got=%0h exp=0", keys_valid); end
      end
      if (k == 7) begin
        vectors++; if (bus.blk[127:120] !== 8'hBF) begin miscompares++; $display("FAIL basic_blk7_hi got=%0h exp=bf", bus.blk[127:120]); end
      end
      $display("basic block %0d accepted data=%032h", k, bus.blk);
      @(negedge clk);
    end
    vectors++; if (bus.blk_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle_after got=%0h exp=0", bus.blk_valid); end
  endtask

  task automatic test_backpressure;
    int idx;
    logic [127:0] prev_blk;
    logic prev_acc;
    idx = 0; prev_acc = 1'b1; prev_blk = '0;
    bus.blk_ready = 1'b0;
    do_capture(st_inc);
    for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
      bus.blk_ready = (cyc % 3 == 0);
      vectors++; if (bus.blk_valid !== 1'b1 || bus.blk !== exp_blk(st_inc, idx) || bus.blk_last !== (idx == 7)) begin miscompares++; $display("FAIL bp_blk%0d got v=%0h d=%0h l=%0h exp=%0h", idx, bus.blk_valid, bus.blk, bus.blk_last, exp_blk(st_inc, idx)); end
      if (!prev_acc) begin
        vectors++; if (bus.blk !== prev_blk) begin miscompares++; $display("FAIL bp_hold got=%0h exp=%0h", bus.blk, prev_blk); end
      end
      prev_blk = bus.blk;
      prev_acc = bus.blk_ready;
      if (bus.blk_ready) begin
        $display("backpressure block %0d accepted at cycle %0d", idx, cyc);
        idx++;
      end
      @(negedge clk);
    end
    vectors++; if (idx !== 8) begin miscompares++; $display("FAIL bp_accepts got=%0d exp=8", idx); end
    vectors++; if (bus.blk_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after got=%0h exp=0", bus.blk_valid); end
  endtask

  task automatic test_back_to_back;
    bus.blk_ready = 1'b1;
    do_capture(st_inc);
    repeat (7) @(negedge clk);
    vectors++; if (bus.blk_last !== 1'b1 || bus.ready !== 1'b1) begin miscompares++; $display("FAIL b2b_last_ready got=%0h/%0h exp=1/1", bus.blk_last, bus.ready); end
    do_capture(st_ff);
    vectors++; if (keys_valid !== 1'b1 || key0 !== {256{1'b1}} || a !== '0) begin miscompares++; $display("FAIL b2b_keys got kv=%0h k0=%0h a=%0h", keys_valid, key0, a); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (bus.blk_valid !== 1'b1 || bus.blk !== {128{1'b1}} || bus.blk_last !== (k == 7)) begin miscompares++; $display("FAIL b2b_blk%0d got v=%0h d=%0h l=%0h", k, bus.blk_valid, bus.blk, bus.blk_last); end
      $display("back-to-back block %0d accepted data=%032h", k, bus.blk);
      @(negedge clk);
    end
    vectors++; if (bus.blk_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after got=%0h exp=0", bus.blk_valid); end
  endtask

  task automatic test_overflow;
    bus.blk_ready = 1'b1;
    do_capture(st_inc);
    repeat (3) @(negedge clk);
    bus.blk_ready = 1'b0;
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ready got=%0h exp=0", bus.ready); end
    do_capture(st_ff);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    vectors++; if (keys_valid !== 1'b0 || key0 !== le_range(st_inc, 0, 32)) begin miscompares++; $display("FAIL ovf_keys got kv=%0h k0=%0h", keys_valid, key0); end
    bus.blk_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      vectors++; if (bus.blk_valid !== 1'b1 || bus.blk !== exp_blk(st_inc, k)) begin miscompares++; $display("FAIL ovf_blk%0d got v=%0h d=%0h exp=%0h", k, bus.blk_valid, bus.blk, exp_blk(st_inc, k)); end
      $display("overflow block %0d accepted data=%032h", k, bus.blk);
      @(negedge clk);
    end
    vectors++; if (overflow !== 1'b1 || bus.blk_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_sticky got ovf=%0h v=%0h exp=1/0", overflow, bus.blk_valid); end
  endtask

  task automatic test_reset_mid;
    bus.blk_ready = 1'b1;
    do_capture(st_inc);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.blk_valid !== 1'b0 || bus.blk !== '0 || bus.blk_last !== 1'b0) begin miscompares++; $display("FAIL rst_mid_blk got v=%0h d=%0h", bus.blk_valid, bus.blk); end
    vectors++; if (key0 !== '0 || key1 !== '0 || a !== '0 || b !== '0) begin miscompares++; $display("FAIL rst_mid_keys got k0=%0h a=%0h", key0, a); end
    vectors++; if (overflow !== 1'b0 || keys_valid !== 1'b0 || bus.ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flags got ovf=%0h kv=%0h rdy=%0h", overflow, keys_valid, bus.ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got=%0h exp=1", bus.ready); end
    $display("mid-stream reset released");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (bus.blk_valid !== 1'b0 || keys_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_quiet%0d got v=%0h kv=%0h exp=0/0", c, bus.blk_valid, keys_valid); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 200; i++) st_inc[1599 - 8*i -: 8] = 8'(i);
    st_ff = '1;
    bus.done = 1'b0;
    bus.state = '0;
    bus.blk_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
